// File: rtl/mdio_phy_manager.sv
// mdio_phy_manager
//   Autonomous PHY management sequencer driving the AXI-Lite slave port of an
//   MDIO master. After reset it waits for the PHY, writes BMCR to enable and
//   restart auto-negotiation, then polls BMSR periodically. Each poll reads
//   BMSR twice because the link bit is latch-low; only the second read is
//   published. Software may request another BMCR write at any time, and
//   transactions that stall or return an error response are abandoned.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b*   AXI-Lite write channels (master side)
//   axi_ar*/axi_r*          AXI-Lite read channels (master side)
//   restart_autoneg         single-cycle request to re-issue the BMCR write
//   link_up                 BMSR[2] from the last successful poll
//   link_change             one-cycle pulse when link_up changes
//   status_valid            set after the first successful poll
//   bmsr_value              last successfully read BMSR
//   mdio_timeout            one-cycle pulse on timeout or error response
module mdio_phy_manager #(
  parameter int          RESET_WAIT_CYCLES    = 1_250_000,
  parameter int          POLL_INTERVAL_CYCLES = 12_500_000,
  parameter int          TIMEOUT_CYCLES       = 125_000,
  parameter logic [15:0] BMCR_INIT_VALUE      = 16'h1200,
  parameter int          AXI_ADDR_W           = 32,
  parameter int          AXI_DATA_W           = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [AXI_ADDR_W-1:0]   axi_awaddr,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [AXI_DATA_W-1:0]   axi_wdata,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [AXI_ADDR_W-1:0]   axi_araddr,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [AXI_DATA_W-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  input  logic                    restart_autoneg,
  output logic                    link_up,
  output logic                    link_change,
  output logic                    status_valid,
  output logic [15:0]             bmsr_value,
  output logic                    mdio_timeout
);

  localparam int MAX_A   = (RESET_WAIT_CYCLES > POLL_INTERVAL_CYCLES) ?
                           RESET_WAIT_CYCLES : POLL_INTERVAL_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Valids rise on the edge the counter reads N-1 (exactly N clocks after
  // entry). The poll interval compares against N, giving the extra clock
  // between the poll-completing handshake and the next arvalid.
  localparam logic [CNT_W-1:0] RW_LAST   = CNT_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_INTERVAL_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_RESET_WAIT, S_BMCR_WRITE, S_BMCR_RESP, S_POLL_WAIT, S_BMSR_READ, S_BMSR_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [AXI_DATA_W-1:0]   wdata_q, wdata_d;
  logic [AXI_DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                    bready_q, bready_d, arvalid_q, arvalid_d;
  logic [AXI_ADDR_W-1:0]   araddr_q, araddr_d;
  logic                    rready_q, rready_d;
  logic                    read_cnt_q, read_cnt_d, pend_q, pend_d;
  logic                    link_up_q, link_up_d, link_change_q, link_change_d;
  logic                    status_valid_q, status_valid_d, timeout_q, timeout_d;
  logic [15:0]             bmsr_q, bmsr_d;
  logic                    fail, timed_out;

  // Only rdata[15:0] carries PHY register contents.
  logic unused_rdata;
  assign unused_rdata = ^axi_rdata[AXI_DATA_W-1:16];

  always_comb begin
    state_d        = state_q;
    cnt_d          = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    bready_d       = bready_q;
    arvalid_d      = arvalid_q;
    araddr_d       = araddr_q;
    rready_d       = rready_q;
    read_cnt_d     = read_cnt_q;
    pend_d         = pend_q | restart_autoneg;
    link_up_d      = link_up_q;
    link_change_d  = 1'b0;
    status_valid_d = status_valid_q;
    bmsr_d         = bmsr_q;
    timeout_d      = 1'b0;
    fail           = 1'b0;
    timed_out      = (cnt_q == TO_LAST);

    case (state_q)
      S_RESET_WAIT: if (cnt_q == RW_LAST) state_d = S_BMCR_WRITE;
      S_POLL_WAIT: begin
        if (pend_q)                  state_d = S_BMCR_WRITE;
        else if (cnt_q == POLL_LAST) state_d = S_BMSR_READ;
      end
      S_BMCR_WRITE: begin
        if (axi_awready) awvalid_d = 1'b0;
        if (axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
          state_d  = S_BMCR_RESP;
          bready_d = 1'b1;
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      S_BMCR_RESP: begin
        if (axi_bvalid) begin
          bready_d = 1'b0;
          if (axi_bresp != 2'b00) fail = 1'b1;
          else                    state_d = S_POLL_WAIT;
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      S_BMSR_READ: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_BMSR_DATA;
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      S_BMSR_DATA: begin
        if (axi_rvalid) begin
          rready_d = 1'b0;
          if (axi_rresp != 2'b00) begin
            fail = 1'b1;
          end else if (!read_cnt_q) begin
            // First read only clears the latched-low link indication.
            read_cnt_d = 1'b1;
            state_d    = S_BMSR_READ;
          end else begin
            read_cnt_d     = 1'b0;
            bmsr_d         = axi_rdata[15:0];
            link_up_d      = axi_rdata[2];
            link_change_d  = axi_rdata[2] ^ link_up_q;
            status_valid_d = 1'b1;
            state_d        = S_POLL_WAIT;
          end
        end else if (timed_out) begin
          fail = 1'b1;
        end
      end
      default: state_d = S_RESET_WAIT;
    endcase

    if (fail) begin
      awvalid_d  = 1'b0;
      wvalid_d   = 1'b0;
      bready_d   = 1'b0;
      arvalid_d  = 1'b0;
      rready_d   = 1'b0;
      read_cnt_d = 1'b0;
      timeout_d  = 1'b1;
      state_d    = S_POLL_WAIT;
    end

    // Entry actions: the counter restarts on every state change and the
    // request channel is raised together with the state register.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == S_BMCR_WRITE) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        wdata_d   = AXI_DATA_W'(BMCR_INIT_VALUE);
        wstrb_d   = '1;
        pend_d    = restart_autoneg;
      end
      if (state_d == S_BMSR_READ) begin
        arvalid_d = 1'b1;
        araddr_d  = AXI_ADDR_W'(5'h01);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_RESET_WAIT;
      cnt_q          <= '0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      bready_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      araddr_q       <= '0;
      rready_q       <= 1'b0;
      read_cnt_q     <= 1'b0;
      pend_q         <= 1'b0;
      link_up_q      <= 1'b0;
      link_change_q  <= 1'b0;
      status_valid_q <= 1'b0;
      bmsr_q         <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      bready_q       <= bready_d;
      arvalid_q      <= arvalid_d;
      araddr_q       <= araddr_d;
      rready_q       <= rready_d;
      read_cnt_q     <= read_cnt_d;
      pend_q         <= pend_d;
      link_up_q      <= link_up_d;
      link_change_q  <= link_change_d;
      status_valid_q <= status_valid_d;
      bmsr_q         <= bmsr_d;
      timeout_q      <= timeout_d;
    end
  end

  assign axi_awaddr   = '0;
  assign axi_awvalid  = awvalid_q;
  assign axi_wdata    = wdata_q;
  assign axi_wstrb    = wstrb_q;
  assign axi_wvalid   = wvalid_q;
  assign axi_bready   = bready_q;
  assign axi_araddr   = araddr_q;
  assign axi_arvalid  = arvalid_q;
  assign axi_rready   = rready_q;
  assign link_up      = link_up_q;
  assign link_change  = link_change_q;
  assign status_valid = status_valid_q;
  assign bmsr_value   = bmsr_q;
  assign mdio_timeout = timeout_q;

endmodule
